// File: rtl/io_bank_pkg.sv
// Shared definitions for the IO bank: commit FSM states and config nibble layout.
package io_bank_pkg;

   localparam int CFG_BITS_PER_CH = 4;

   localparam int BIT_OUT_REG = 0;
   localparam int BIT_IN_REG  = 1;
   localparam int BIT_T_INV   = 2;
   localparam int BIT_IN_SYNC = 3;

   typedef enum logic [1:0] {
      ST_ACTIVE  = 2'd0,
      ST_QUIESCE = 2'd1,
      ST_APPLY   = 2'd2
   } state_e;

endpackage

// File: rtl/io_bank_channel.sv
// One bidirectional IO channel: output/tristate path with optional register, input capture path.
// IO_BANK_SYNC_EN adds a second input flop selected by the IN_SYNC config bit.
module io_bank_channel
   import io_bank_pkg::*;
(
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic [CFG_BITS_PER_CH-1:0] cfg_i,
   input  logic                       busy_i,
   input  logic                       fab_i_i,
   input  logic                       fab_t_i,
   input  logic                       o_top_i,
   output logic                       i_top_o,
   output logic                       t_top_o,
   output logic                       fab_o_o,
   output logic                       fab_q_o
);

   logic i_q;
   logic t_q;
   logic hold_q;
   logic s1_q;
   logic i_path;
   logic t_path;

   assign t_path  = fab_t_i ^ cfg_i[BIT_T_INV];
   assign i_path  = cfg_i[BIT_OUT_REG] ? i_q : fab_i_i;
   // hold_q keeps the value last shown on the pad so a commit never glitches I_top
   assign i_top_o = busy_i ? hold_q : i_path;
   assign t_top_o = busy_i | (cfg_i[BIT_OUT_REG] ? t_q : t_path);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         i_q    <= 1'b0;
         t_q    <= 1'b0;
         hold_q <= 1'b0;
         s1_q   <= 1'b0;
      end else begin
         i_q  <= fab_i_i;
         t_q  <= t_path;
         s1_q <= o_top_i;
         if (!busy_i) begin
            hold_q <= i_path;
         end
      end
   end

`ifdef IO_BANK_SYNC_EN
   logic s2_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         s2_q <= 1'b0;
      end else begin
         s2_q <= s1_q;
      end
   end

   assign fab_q_o = cfg_i[BIT_IN_SYNC] ? s2_q : s1_q;
`else
   logic unused_in_sync;
   assign unused_in_sync = cfg_i[BIT_IN_SYNC];
   assign fab_q_o        = s1_q;
`endif

   assign fab_o_o = cfg_i[BIT_IN_REG] ? fab_q_o : o_top_i;

endmodule

// File: rtl/io_bank_cfg.sv
// IO bank: shadow/active config registers with a quiesce-then-apply commit FSM, NUM_CH channels.
// Optional macro IO_BANK_SYNC_EN enables the two-flop input path in each channel.
module io_bank_cfg
   import io_bank_pkg::*;
#(
   parameter int NUM_CH     = 4,
   parameter int FRAME_BITS = 32
) (
   input  logic                          UserCLK,
   input  logic                          UserRSTn,
   input  logic [FRAME_BITS-1:0]         FrameData,
   input  logic                          FrameStrobe,
   input  logic                          cfg_commit,
   output logic                          cfg_busy,
   input  logic [NUM_CH-1:0]             fab_I,
   input  logic [NUM_CH-1:0]             fab_T,
   output logic [NUM_CH-1:0]             fab_O,
   output logic [NUM_CH-1:0]             fab_Q,
   output logic [NUM_CH-1:0]             I_top,
   output logic [NUM_CH-1:0]             T_top,
   input  logic [NUM_CH-1:0]             O_top,
   output logic [NUM_CH*CFG_BITS_PER_CH-1:0] C_bits
);

   localparam int CB = NUM_CH * CFG_BITS_PER_CH;

   state_e        state_q;
   logic          busy_q;
   logic [CB-1:0] shadow_q;
   logic [CB-1:0] active_q;

   generate
      if (FRAME_BITS > CB) begin : g_frame_unused
         logic unused_frame_hi;
         assign unused_frame_hi = ^FrameData[FRAME_BITS-1:CB];
      end
   endgenerate

   // Shadow writes are independent of the FSM, so a strobe in APPLY lands after the copy.
   always_ff @(posedge UserCLK or negedge UserRSTn) begin
      if (!UserRSTn) begin
         state_q  <= ST_ACTIVE;
         busy_q   <= 1'b0;
         shadow_q <= '0;
         active_q <= '0;
      end else begin
         if (FrameStrobe) begin
            shadow_q <= FrameData[CB-1:0];
         end
         case (state_q)
            ST_ACTIVE: begin
               if (cfg_commit) begin
                  state_q <= ST_QUIESCE;
                  busy_q  <= 1'b1;
               end
            end
            ST_QUIESCE: begin
               state_q <= ST_APPLY;
            end
            ST_APPLY: begin
               state_q  <= ST_ACTIVE;
               busy_q   <= 1'b0;
               active_q <= shadow_q;
            end
            default: begin
               state_q <= ST_ACTIVE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign cfg_busy = busy_q;
   assign C_bits   = active_q;

   generate
      for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
         io_bank_channel u_ch (
            .clk_i   (UserCLK),
            .rst_ni  (UserRSTn),
            .cfg_i   (active_q[gi*CFG_BITS_PER_CH +: CFG_BITS_PER_CH]),
            .busy_i  (busy_q),
            .fab_i_i (fab_I[gi]),
            .fab_t_i (fab_T[gi]),
            .o_top_i (O_top[gi]),
            .i_top_o (I_top[gi]),
            .t_top_o (T_top[gi]),
            .fab_o_o (fab_O[gi]),
            .fab_q_o (fab_Q[gi])
         );
      end
   endgenerate

endmodule

// File: tb/tb_io_bank_cfg.sv
// Self-checking bench for io_bank_cfg: table vectors, directed commit/reset sequences, random traffic vs a model.
module tb_io_bank_cfg;

   logic        UserCLK = 1'b0;
   logic        UserRSTn;
   logic [31:0] FrameData;
   logic        FrameStrobe;
   logic        cfg_commit;
   logic        cfg_busy;
   logic [3:0]  fab_I, fab_T, fab_O, fab_Q, I_top, T_top, O_top;
   logic [15:0] C_bits;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 UserCLK = ~UserCLK;

   io_bank_cfg #(.NUM_CH(4), .FRAME_BITS(32)) dut (
      .UserCLK     (UserCLK),
      .UserRSTn    (UserRSTn),
      .FrameData   (FrameData),
      .FrameStrobe (FrameStrobe),
      .cfg_commit  (cfg_commit),
      .cfg_busy    (cfg_busy),
      .fab_I       (fab_I),
      .fab_T       (fab_T),
      .fab_O       (fab_O),
      .fab_Q       (fab_Q),
      .I_top       (I_top),
      .T_top       (T_top),
      .O_top       (O_top),
      .C_bits      (C_bits)
   );

   // Reference model: config words, busy countdown, last-edge samples of the fabric/pad inputs.
   logic [15:0] m_shadow, m_active;
   int          m_busy;
   logic [3:0]  m_iflop, m_tflop, m_hold, m_o1, m_o2;

   function automatic logic [3:0] nib(input logic [15:0] cfg, input int b);
      logic [3:0] r;
      for (int c = 0; c < 4; c++) r[c] = cfg[4*c+b];
      return r;
   endfunction

   function automatic logic [3:0] exp_I();
      logic [3:0] orr;
      orr = nib(m_active, 0);
      if (m_busy != 0) return m_hold;
      return (orr & m_iflop) | (~orr & fab_I);
   endfunction

   function automatic logic [3:0] exp_T();
      logic [3:0] orr;
      orr = nib(m_active, 0);
      if (m_busy != 0) return 4'hF;
      return (orr & m_tflop) | (~orr & (fab_T ^ nib(m_active, 2)));
   endfunction

   function automatic logic [3:0] exp_Q();
      logic [3:0] syn;
`ifdef IO_BANK_SYNC_EN
      syn = nib(m_active, 3);
`else
      syn = 4'h0;
`endif
      return (syn & m_o2) | (~syn & m_o1);
   endfunction

   function automatic logic [3:0] exp_O();
      logic [3:0] ir;
      ir = nib(m_active, 1);
      return (ir & exp_Q()) | (~ir & O_top);
   endfunction

   task automatic model_reset();
      m_shadow = '0; m_active = '0; m_busy = 0;
      m_iflop = '0; m_tflop = '0; m_hold = '0; m_o1 = '0; m_o2 = '0;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic check_all(input string nm);
      chk({nm, ".busy"},  {31'd0, cfg_busy}, {31'd0, m_busy != 0});
      chk({nm, ".C_bits"}, {16'd0, C_bits}, {16'd0, m_active});
      chk({nm, ".I_top"}, {28'd0, I_top}, {28'd0, exp_I()});
      chk({nm, ".T_top"}, {28'd0, T_top}, {28'd0, exp_T()});
      chk({nm, ".fab_Q"}, {28'd0, fab_Q}, {28'd0, exp_Q()});
      chk({nm, ".fab_O"}, {28'd0, fab_O}, {28'd0, exp_O()});
   endtask

   // Advance one clock edge, updating the model from the inputs present at that edge.
   task automatic step();
      logic [15:0] old_sh;
      logic [3:0]  cur_I;
      old_sh = m_shadow;
      cur_I  = exp_I();
      if (UserRSTn) begin
         if (m_busy == 0) m_hold = cur_I;
         m_iflop = fab_I;
         m_tflop = fab_T ^ nib(m_active, 2);
         m_o2    = m_o1;
         m_o1    = O_top;
         if (FrameStrobe) m_shadow = FrameData[15:0];
         if (m_busy == 1) begin
            m_active = old_sh;
            m_busy   = 0;
         end else if (m_busy == 2) begin
            m_busy = 1;
         end else if (cfg_commit) begin
            m_busy = 2;
         end
      end
      @(posedge UserCLK);
      #1;
   endtask

   task automatic commit_cfg(input logic [15:0] cfg);
      FrameData = {16'hDEAD, cfg}; FrameStrobe = 1'b1; step(); check_all("cfg_strobe");
      FrameStrobe = 1'b0; cfg_commit = 1'b1; step(); check_all("cfg_quiesce");
      cfg_commit = 1'b0; step(); check_all("cfg_apply");
      step(); check_all("cfg_done");
      $display("txn commit cfg=%h C_bits=%h", cfg, C_bits);
   endtask

   typedef struct {
      logic [15:0] cfg;
      logic [3:0]  fi, ft, ot;
      logic [3:0]  ei, et, eo;
   } vec_t;

   vec_t tbl[5];
   int   n;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{16'h0000, 4'hA, 4'h0, 4'h5, 4'hA, 4'h0, 4'h5};
      tbl[1] = '{16'h0000, 4'h3, 4'hC, 4'h9, 4'h3, 4'hC, 4'h9};
      tbl[2] = '{16'h4444, 4'hF, 4'h0, 4'h0, 4'hF, 4'hF, 4'h0};
      tbl[3] = '{16'h4444, 4'h0, 4'h6, 4'h6, 4'h0, 4'h9, 4'h6};
      tbl[4] = '{16'h0404, 4'h7, 4'h0, 4'h2, 4'h7, 4'h5, 4'h2};

      UserRSTn = 1'b0; FrameData = '0; FrameStrobe = 1'b0; cfg_commit = 1'b0;
      fab_I = '0; fab_T = '0; O_top = 4'hF;
      model_reset();
      #2;
      fab_I = 4'hA; fab_T = 4'h0; #1;
      chk("rst_I_top", {28'd0, I_top}, 32'hA);
      chk("rst_T_top", {28'd0, T_top}, 32'h0);
      chk("rst_C_bits", {16'd0, C_bits}, 32'h0);
      chk("rst_busy", {31'd0, cfg_busy}, 32'h0);
      chk("rst_fab_Q", {28'd0, fab_Q}, 32'h0);
      chk("rst_fab_O", {28'd0, fab_O}, 32'hF);
      step(); check_all("rst_edge");
      $display("txn reset I_top=%h T_top=%h fab_Q=%h", I_top, T_top, fab_Q);
      @(negedge UserCLK); UserRSTn = 1'b1;
      step(); chk("first_edge_fab_Q", {28'd0, fab_Q}, 32'hF);

      for (int i = 0; i < 5; i++) begin
         if (tbl[i].cfg != m_active) commit_cfg(tbl[i].cfg);
         fab_I = tbl[i].fi; fab_T = tbl[i].ft; O_top = tbl[i].ot; #1;
         chk("tbl_I_top", {28'd0, I_top}, {28'd0, tbl[i].ei});
         chk("tbl_T_top", {28'd0, T_top}, {28'd0, tbl[i].et});
         chk("tbl_fab_O", {28'd0, fab_O}, {28'd0, tbl[i].eo});
         $display("txn vec %0d I_top=%h T_top=%h fab_O=%h", i, I_top, T_top, fab_O);
         step();
      end

      // Registered output path, busy window forces pads released
      FrameData = 32'h0000_1111; FrameStrobe = 1'b1; step();
      FrameStrobe = 1'b0; cfg_commit = 1'b1; step();
      chk("c1_busy_q", {31'd0, cfg_busy}, 32'h1);
      chk("c1_T_top_q", {28'd0, T_top}, 32'hF);
      check_all("c1_q");
      cfg_commit = 1'b0; step();
      chk("c1_busy_a", {31'd0, cfg_busy}, 32'h1);
      chk("c1_T_top_a", {28'd0, T_top}, 32'hF);
      step();
      chk("c1_busy_done", {31'd0, cfg_busy}, 32'h0);
      chk("c1_C_bits", {16'd0, C_bits}, 32'h1111);
      fab_I = 4'h3; step();
      fab_I = 4'h5; #1;
      chk("c1_I_lag", {28'd0, I_top}, 32'h3);
      step();
      chk("c1_I_after", {28'd0, I_top}, 32'h5);
      check_all("c1_end");
      $display("txn out_reg C_bits=%h I_top=%h", C_bits, I_top);

      // Tristate inversion on channel 0
      commit_cfg(16'h0004);
      fab_T = 4'h0; #1;
      chk("tinv_T0_hi", {31'd0, T_top[0]}, 32'h1);
      step();
      fab_T = 4'h1; #1;
      chk("tinv_T0_lo", {31'd0, T_top[0]}, 32'h0);
      check_all("tinv");
      step();
      $display("txn t_inv T_top=%h", T_top);

      // Strobe and commit at the same edge apply the new frame
      FrameData = 32'h0000_0002; FrameStrobe = 1'b1; cfg_commit = 1'b1; step();
      FrameStrobe = 1'b0; cfg_commit = 1'b0; step(); step();
      chk("same_edge_C", {28'd0, C_bits[3:0]}, 32'h2);
      O_top = 4'h0; step();
      O_top = 4'h1; #1;
      chk("in_reg_fabO_old", {31'd0, fab_O[0]}, {31'd0, fab_Q[0]});
      chk("in_reg_fabO_0", {31'd0, fab_O[0]}, 32'h0);
      step();
      chk("in_reg_fabO_1", {31'd0, fab_O[0]}, 32'h1);
      check_all("in_reg");
      $display("txn in_reg fab_O=%h fab_Q=%h", fab_O, fab_Q);

      // Strobe at the APPLY->ACTIVE edge keeps the new frame pending
      FrameData = 32'h0000_0040; FrameStrobe = 1'b1; step();
      FrameStrobe = 1'b0; cfg_commit = 1'b1; step();
      cfg_commit = 1'b0; step();
      FrameData = 32'h0000_0400; FrameStrobe = 1'b1; step();
      FrameStrobe = 1'b0;
      chk("late_strobe_C", {16'd0, C_bits}, 32'h0040);
      cfg_commit = 1'b1; step(); cfg_commit = 1'b0; step(); step();
      chk("pending_C", {16'd0, C_bits}, 32'h0400);
      $display("txn late_strobe C_bits=%h", C_bits);

      // Commit during QUIESCE is ignored
      cfg_commit = 1'b1; step();
      n = 0;
      while (cfg_busy && n < 10) begin
         n++;
         step();
      end
      cfg_commit = 1'b0;
      chk("busy_len", n, 2);
      check_all("busy_len");
      $display("txn busy_cycles=%0d", n);

      // Reset asserted in APPLY aborts the commit
      FrameData = 32'h0000_FFFF; FrameStrobe = 1'b1; step();
      FrameStrobe = 1'b0; cfg_commit = 1'b1; step();
      cfg_commit = 1'b0; step();
      #2; UserRSTn = 1'b0; model_reset(); #1;
      chk("abort_busy", {31'd0, cfg_busy}, 32'h0);
      chk("abort_C", {16'd0, C_bits}, 32'h0);
      check_all("abort");
      step(); check_all("abort_hold");
      @(negedge UserCLK); UserRSTn = 1'b1;
      step(); check_all("abort_rel");
      $display("txn abort C_bits=%h busy=%b", C_bits, cfg_busy);

      // IN_SYNC latency
      commit_cfg(16'h0008);
      O_top = 4'h0; step(); step();
      O_top = 4'h1;
      n = 0;
      do begin
         step();
         n++;
      end while (fab_Q[0] !== 1'b1 && n < 5);
`ifdef IO_BANK_SYNC_EN
      chk("in_sync_lat", n, 2);
`else
      chk("in_sync_lat", n, 1);
`endif
      $display("txn in_sync latency=%0d", n);

      for (int i = 0; i < 300; i++) begin
         FrameData   = $urandom;
         FrameStrobe = ($urandom_range(0, 3) == 0);
         cfg_commit  = ($urandom_range(0, 2) == 0);
         fab_I       = 4'($urandom);
         fab_T       = 4'($urandom);
         O_top       = 4'($urandom);
         #1;
         check_all("rnd_comb");
         step();
         check_all("rnd_seq");
         $display("txn rnd %0d C_bits=%h busy=%b I_top=%h T_top=%h fab_O=%h fab_Q=%h",
                  i, C_bits, cfg_busy, I_top, T_top, fab_O, fab_Q);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/io_bank_cfg.md
IO_BANK_CFG -- requirements
Module: io_bank_cfg

Interface
REQ-001 Parameter NUM_CH, default 4: number of bidirectional IO channels, range 1..8.
REQ-002 Parameter FRAME_BITS, default 32: FrameData width; NUM_CH*4 SHALL be <= FRAME_BITS.
REQ-003 UserCLK  in  1  sole clock, rising edge.
REQ-004 UserRSTn  in  1  asynchronous active-low reset.
REQ-005 FrameData  in  FRAME_BITS  config frame; bits [4c+3:4c] are the config nibble for channel c.
REQ-006 FrameStrobe  in  1  frame write strobe; one cycle high writes the shadow config.
REQ-007 cfg_commit  in  1  request to move shadow config to active config.
REQ-008 cfg_busy  out  1  high while a commit is in progress.
REQ-009 fab_I / fab_T  in  NUM_CH each  fabric-side output data and tristate (T=1 means pad released).
REQ-010 fab_O / fab_Q  out  NUM_CH each  fabric-side pad input: fab_O optionally registered, fab_Q always registered.
REQ-011 I_top / T_top  out  NUM_CH each  pad-side data and tristate.
REQ-012 O_top  in  NUM_CH  pad input.
REQ-013 C_bits  out  NUM_CH*4  active config readback.

Function
REQ-014 Per-channel nibble: bit0 OUT_REG, bit1 IN_REG, bit2 T_INV, bit3 IN_SYNC.
REQ-015 A FrameStrobe high at an edge SHALL load shadow[NUM_CH*4-1:0] from FrameData in any state; FrameData bits above NUM_CH*4 are ignored.
REQ-016 FSM states ACTIVE, QUIESCE, APPLY; reset state ACTIVE.
REQ-017 ACTIVE with cfg_commit=1 -> QUIESCE; QUIESCE -> APPLY unconditionally; APPLY -> ACTIVE, loading active config from shadow at that edge.
REQ-018 cfg_commit outside ACTIVE SHALL be ignored; a commit accepted with FrameStrobe at the same edge SHALL apply the new frame, because the shadow updates before APPLY.
REQ-019 FrameStrobe at the APPLY->ACTIVE edge SHALL apply the old shadow; the new value stays pending in shadow.
REQ-020 cfg_busy SHALL be 1 in QUIESCE and APPLY and 0 in ACTIVE.
REQ-021 While cfg_busy=1, all T_top SHALL be 1 and I_top SHALL hold its last value.
REQ-022 OUT_REG=0: I_top=fab_I and T_top=fab_T^T_INV combinationally; OUT_REG=1: both come from a flop with 1-cycle latency, the T flop holding fab_T^T_INV.
REQ-023 fab_Q = O_top delayed 1 cycle, or 2 cycles when IN_SYNC is effective (REQ-031).
REQ-024 fab_O = O_top combinationally when IN_REG=0, else fab_Q.
REQ-025 C_bits SHALL equal the active config at all times.

Reset
REQ-026 Reset SHALL asynchronously clear shadow, active config, all data flops and synchroniser stages to 0, and force the FSM to ACTIVE.
REQ-027 During and after reset: cfg_busy=0, fab_Q=0, C_bits=0; I_top, T_top and fab_O follow the combinational path of an all-zero config.
REQ-028 Reset asserted mid-commit SHALL abort the commit and leave active config at 0.
REQ-029 Release SHALL be synchronised by the instantiating tile; the block needs no internal reset synchroniser.

Configuration
REQ-030 Macro IO_BANK_SYNC_EN.
REQ-031 When defined, IN_SYNC=1 inserts a second flop on the fab_Q path, giving 2-cycle latency.
REQ-032 When undefined, bit3 SHALL be stored and read back on C_bits but SHALL have no effect on the datapath.

Structure
REQ-033 Shared package io_bank_pkg SHALL hold the FSM state enum, the nibble bit-index constants and CFG_BITS_PER_CH=4.
REQ-034 The per-channel datapath SHALL be a sub-module io_bank_channel, instantiated NUM_CH times; the FSM and config registers stay in the top.

Verification
REQ-035 Reset, then drive fab_I=4'b1010, fab_T=0 -> I_top=4'b1010, T_top=0 in the same cycle; C_bits=0; fab_Q=0 until the first edge.
REQ-036 FrameStrobe with FrameData=32'h0000_1111, then cfg_commit -> cfg_busy=1 for 2 cycles with T_top=4'hF; afterwards C_bits=16'h1111 and I_top lags fab_I by 1 cycle.
REQ-037 Commit nibble 4'h4 on ch0, drive fab_T[0]=0 -> T_top[0]=1; drive fab_T[0]=1 -> T_top[0]=0.
REQ-038 Assert FrameStrobe and cfg_commit at the same edge with FrameData=32'h2 -> after APPLY C_bits[3:0]=4'h2 and fab_O[0]=fab_Q[0].
REQ-039 cfg_commit during QUIESCE is ignored (busy for exactly 2 cycles); reset asserted in APPLY -> C_bits=0 and cfg_busy=0 immediately.
REQ-040 With IO_BANK_SYNC_EN and nibble 4'h8, a step on O_top[0] reaches fab_Q[0] after 2 edges; without the macro, after 1 edge.
